// File: rtl/time_keeper_pkg.sv
// Shared widths, field limits and increment helpers for the time-of-day counter.
package time_keeper_pkg;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MS_W   = 6;

   localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
   localparam logic [MS_W-1:0]   MIN_MAX  = MS_W'(59);
   localparam logic [MS_W-1:0]   SEC_MAX  = MS_W'(59);
   localparam logic [HOUR_W-1:0] HALF_DAY = HOUR_W'(12);

   localparam int unsigned UP_W = 3;

   typedef enum logic [1:0] {
      UP_HOUR = 2'd0,
      UP_MIN  = 2'd1,
      UP_SEC  = 2'd2
   } up_bit_e;

   function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v,
                                              input logic [MS_W-1:0] max_v);
      return (v >= max_v) ? '0 : v + MS_W'(1);
   endfunction

   function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] v);
      return (v >= HOUR_MAX) ? '0 : v + HOUR_W'(1);
   endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Input levels and time/display outputs of the time-of-day counter.
interface time_keeper_if;
   import time_keeper_pkg::*;

   logic                 tick;
   logic                 set_clock;
   logic [UP_W-1:0]      up_clock;
   logic                 mode_ampm;
   logic [HOUR_W-1:0]    hour;
   logic [MS_W-1:0]      minute;
   logic [MS_W-1:0]      second;
   logic [HOUR_W-1:0]    hour_disp;
   logic                 pm;
   logic                 day_carry;

   modport master (
      output tick, set_clock, up_clock, mode_ampm,
      input  hour, minute, second, hour_disp, pm, day_carry
   );

   modport slave (
      input  tick, set_clock, up_clock, mode_ampm,
      output hour, minute, second, hour_disp, pm, day_carry
   );

endinterface

// File: rtl/time_keeper_edge_detect.sv
// Optional N-flop synchroniser followed by a rising-edge detector (one-cycle pulse).
module edge_detect #(
   parameter int unsigned SYNC_STAGES = 0,
   parameter int unsigned WIDTH       = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] sync_w;
   logic [WIDTH-1:0] valid_w;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] armed_q;
   logic [WIDTH-1:0] armed_d;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign sync_w  = d_i;
         assign valid_w = '1;
      end else begin : g_sync
         logic [WIDTH-1:0]       stage_q [SYNC_STAGES];
         logic [SYNC_STAGES-1:0] valid_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                  stage_q[i] <= '0;
               end
               valid_q <= '0;
            end else begin
               stage_q[0] <= d_i;
               valid_q[0] <= 1'b1;
               for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                  stage_q[i] <= stage_q[i-1];
                  valid_q[i] <= valid_q[i-1];
               end
            end
         end

         assign sync_w  = stage_q[SYNC_STAGES-1];
         assign valid_w = {WIDTH{valid_q[SYNC_STAGES-1]}};
      end
   endgenerate

   // A bit is armed only after a genuine low has been seen since reset, so a
   // level held high across reset release never yields a rise.
   always_comb begin
      armed_d = armed_q | (valid_w & ~sync_w);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q  <= '0;
         armed_q <= '0;
      end else begin
         prev_q  <= sync_w;
         armed_q <= armed_d;
      end
   end

   assign rise_o = sync_w & ~prev_q & armed_q;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with set mode and 12/24-hour display.
// Build option: TIME_KEEPER_SEC_CLEAR_EN makes the set-mode second button zero seconds.
module time_keeper
   import time_keeper_pkg::*;
#(
   parameter int unsigned RESET_HOUR = 0,
   parameter int unsigned RESET_MIN  = 0,
   parameter int unsigned RESET_SEC  = 0
) (
   input  logic          clock_50MHz,
   input  logic          reset,
   time_keeper_if.slave  bus
);

   logic                tick_rise;
   logic [UP_W-1:0]     up_rise;

   logic [HOUR_W-1:0]   hour_q, hour_d;
   logic [MS_W-1:0]     min_q, min_d;
   logic [MS_W-1:0]     sec_q, sec_d;
   logic                day_carry_q, day_carry_d;

   logic [HOUR_W-1:0]   hour_disp_w;
   logic                pm_w;

   edge_detect #(
      .SYNC_STAGES (0),
      .WIDTH       (1)
   ) u_tick_edge (
      .clk_i  (clock_50MHz),
      .rst_i  (reset),
      .d_i    (bus.tick),
      .rise_o (tick_rise)
   );

   edge_detect #(
      .SYNC_STAGES (2),
      .WIDTH       (UP_W)
   ) u_up_edge (
      .clk_i  (clock_50MHz),
      .rst_i  (reset),
      .d_i    (bus.up_clock),
      .rise_o (up_rise)
   );

   always_comb begin
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      day_carry_d = 1'b0;
      if (bus.set_clock) begin
         if (up_rise[UP_HOUR]) hour_d = inc_hour(hour_q);
         if (up_rise[UP_MIN])  min_d  = inc_ms(min_q, MIN_MAX);
         if (up_rise[UP_SEC]) begin
`ifdef TIME_KEEPER_SEC_CLEAR_EN
            sec_d = '0;
`else
            sec_d = inc_ms(sec_q, SEC_MAX);
`endif
         end
      end else if (tick_rise) begin
         sec_d = inc_ms(sec_q, SEC_MAX);
         if (sec_q == SEC_MAX) begin
            min_d = inc_ms(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
               hour_d      = inc_hour(hour_q);
               day_carry_d = (hour_q == HOUR_MAX);
            end
         end
      end
   end

   always_ff @(posedge clock_50MHz) begin
      if (reset) begin
         hour_q      <= HOUR_W'(RESET_HOUR);
         min_q       <= MS_W'(RESET_MIN);
         sec_q       <= MS_W'(RESET_SEC);
         day_carry_q <= 1'b0;
      end else begin
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         day_carry_q <= day_carry_d;
      end
   end

   always_comb begin
      hour_disp_w = hour_q;
      pm_w        = 1'b0;
      if (bus.mode_ampm) begin
         pm_w = (hour_q >= HALF_DAY);
         if (hour_q == '0 || hour_q == HALF_DAY) begin
            hour_disp_w = HALF_DAY;
         end else if (hour_q > HALF_DAY) begin
            hour_disp_w = hour_q - HALF_DAY;
         end
      end
   end

   assign bus.hour      = hour_q;
   assign bus.minute    = min_q;
   assign bus.second    = sec_q;
   assign bus.day_carry = day_carry_q;
   assign bus.hour_disp = hour_disp_w;
   assign bus.pm        = pm_w;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper (reset time 23:59:58).
module tb_time_keeper;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   time_keeper_if bus();

   time_keeper #(
      .RESET_HOUR (23),
      .RESET_MIN  (59),
      .RESET_SEC  (58)
   ) dut (
      .clock_50MHz (clk),
      .reset       (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int exp12 [24] = '{12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                      12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s, input int dc);
      check({tag, ".hour"}, 32'(bus.hour), h);
      check({tag, ".minute"}, 32'(bus.minute), m);
      check({tag, ".second"}, 32'(bus.second), s);
      check({tag, ".day_carry"}, 32'(bus.day_carry), dc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_up(input logic [2:0] bits, input int n);
      repeat (n) begin
         bus.up_clock = bits;
         step(3);
         bus.up_clock = '0;
         step(4);
      end
   endtask

   // Expected second after n set-mode second pulses from a given start value.
   function automatic int sec_after(input int start, input int n);
`ifdef TIME_KEEPER_SEC_CLEAR_EN
      return (n > 0) ? 0 : start;
`else
      return (start + n) % 60;
`endif
   endfunction

   int s_exp;

   initial begin
      rst           = 1'b1;
      bus.tick      = 1'b0;
      bus.set_clock = 1'b0;
      bus.up_clock  = '0;
      bus.mode_ampm = 1'b0;
      step(3);
      check_time("reset", 23, 59, 58, 0);

      // Normal counting and midnight rollover
      rst = 1'b0;
      step(1);
      bus.tick = 1'b1;
      step(1);
      check_time("tick1", 23, 59, 59, 0);
      step(1);
      check_time("tick_hold", 23, 59, 59, 0);
      bus.tick = 1'b0;
      step(1);
      bus.tick = 1'b1;
      step(1);
      check_time("rollover", 0, 0, 0, 1);
      step(1);
      check_time("carry_clear", 0, 0, 0, 0);
      bus.tick = 1'b0;

      // Hour sweep through the display in both modes
      bus.set_clock = 1'b1;
      step(1);
      for (int h = 0; h < 24; h++) begin
         bus.mode_ampm = 1'b1;
         #1;
         check("disp12", 32'(bus.hour_disp), exp12[h]);
         check("pm12", 32'(bus.pm), (h >= 12) ? 1 : 0);
         bus.mode_ampm = 1'b0;
         #1;
         check("disp24", 32'(bus.hour_disp), h);
         check("pm24", 32'(bus.pm), 0);
         pulse_up(3'b001, 1);
      end
      check_time("sweep_wrap", 0, 0, 0, 0);

      // Set 10:20:30, then tick must be ignored in set mode
      pulse_up(3'b111, 10);
      pulse_up(3'b110, 10);
      pulse_up(3'b100, 10);
      s_exp = sec_after(sec_after(sec_after(0, 10), 10), 10);
      check_time("set_10_20_30", 10, 20, s_exp, 0);
      for (int i = 0; i < 10; i++) begin
         bus.tick = ~bus.tick;
         step(1);
         check("frozen_dc", 32'(bus.day_carry), 0);
      end
      check_time("frozen", 10, 20, s_exp, 0);

      // Second button
      pulse_up(3'b100, 15);
      s_exp = sec_after(s_exp, 15);
      check("sec_45", 32'(bus.second), s_exp);
      pulse_up(3'b100, 1);
      s_exp = sec_after(s_exp, 1);
      check("sec_up", 32'(bus.second), s_exp);

      // Hour and minute wrap together, with sync latency
      pulse_up(3'b011, 13);
      pulse_up(3'b010, 26);
      check_time("at_23_59", 23, 59, s_exp, 0);
      bus.up_clock = 3'b011;
      step(1);
      check_time("lat1", 23, 59, s_exp, 0);
      step(1);
      check_time("lat2", 23, 59, s_exp, 0);
      step(1);
      check_time("lat3", 0, 0, s_exp, 0);
      bus.up_clock = '0;
      step(4);

      // Run mode: buttons ignored, tick counts
      bus.set_clock = 1'b0;
      step(1);
      pulse_up(3'b010, 1);
      check("up_ignored", 32'(bus.minute), 0);
      bus.tick = 1'b1;
      step(1);
      s_exp = (s_exp + 1) % 60;
      check("run_tick", 32'(bus.second), s_exp);
      bus.tick = 1'b0;
      step(1);

      // set_clock changing at the same edge as a tick rise
      bus.tick      = 1'b1;
      bus.set_clock = 1'b1;
      step(1);
      check("set_same_edge", 32'(bus.second), s_exp);
      bus.tick = 1'b0;
      step(1);
      bus.tick      = 1'b1;
      bus.set_clock = 1'b0;
      step(1);
      s_exp = (s_exp + 1) % 60;
      check("clr_same_edge", 32'(bus.second), s_exp);
      bus.tick = 1'b0;
      step(1);

      // Button held through reset release
      bus.set_clock = 1'b1;
      bus.up_clock  = 3'b001;
      rst           = 1'b1;
      step(2);
      rst = 1'b0;
      step(6);
      check_time("held_up", 23, 59, 58, 0);
      bus.up_clock = '0;
      step(4);
      check("held_up_fall", 32'(bus.hour), 23);
      pulse_up(3'b001, 1);
      check("up_after_rel", 32'(bus.hour), 0);

      // Reset on the same edge as a rollover tick
      bus.set_clock = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      bus.tick = 1'b1;
      step(1);
      check_time("pre_rst_tick", 23, 59, 59, 0);
      bus.tick = 1'b0;
      step(1);
      bus.tick = 1'b1;
      rst      = 1'b1;
      step(1);
      check_time("rst_tick", 23, 59, 58, 0);
      rst = 1'b0;
      step(3);
      check_time("tick_held_rel", 23, 59, 58, 0);
      bus.tick = 1'b0;
      step(1);
      bus.tick = 1'b1;
      step(1);
      check_time("post_rst_tick", 23, 59, 59, 0);
      bus.tick = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
